osd_host_reg_master_sim: RTL
============================

// Module: osd_host_reg_master_sim
// PURPOSE
//  Simulation-side host endpoint of the GLIP 16-bit channel pair feeding the system's c_glip_in/c_glip_out.
//  Turns single register-access commands into length-prefixed DII request packets and parses the matching responses.
//  Lets tile/debug-module benches do OSD register reads/writes with no TCP host; one transaction in flight.
// PARAMETERS
//  HOST_ADDR     16'h0000  DII address of this host; SRC of requests, required DEST of responses
//  TIMEOUT_CYC   4096      cycles from last request word accepted to response LEN word (OSD_HOST_TIMEOUT_EN only)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous active-high reset
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   command accepted this cycle when cmd_valid & cmd_ready
//  cmd_write    in   1   1 = register write, 0 = register read
//  cmd_dest     in   16  DII destination module address
//  cmd_addr     in   16  register address
//  cmd_wdata    in   16  write data (ignored on read)
//  tx_data      out  16  word toward system (c_glip_in.data)
//  tx_valid     out  1   tx word valid
//  tx_ready     in   1   system accepts tx word
//  rx_data      in   16  word from system (c_glip_out.data)
//  rx_valid     in   1   rx word valid
//  rx_ready     out  1   host accepts rx word
//  rsp_valid    out  1   one-cycle pulse: transaction finished
//  rsp_rdata    out  16  read data (0 for writes/errors)
//  rsp_err      out  1   error response, malformed/misrouted response, or timeout
//  drop_cnt     out  16  count of rx packets discarded while no response awaited (saturating)
// BEHAVIOUR
//  Reset: cmd_ready=0, tx_valid=0, tx_data=0, rx_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, drop_cnt=0; FSM->IDLE.
//  Reset mid-packet abandons it immediately; the peer sees a truncated packet (bench must reset both ends).
//  Packet = LEN word (count of words after it), DEST, SRC, FLAGS, payload. FLAGS[15:14]=TYPE (00=REG), [13:10]=SUB, rest 0.
//  Read req: LEN=4, DEST=cmd_dest, SRC=HOST_ADDR, FLAGS SUB=REQ_READ16, ADDR.  Write req: LEN=5, ...SUB=REQ_WRITE16, ADDR, DATA.
//  States: IDLE -> TX (word index 0..LEN) -> RX_WAIT -> RX (word index) -> DONE -> IDLE.
//  IDLE: cmd_ready=1, rx_ready=1; cmd fields latched on acceptance; cmd_ready drops the next cycle.
//  IDLE rx: whole packet (LEN+1 words) drained, drop_cnt+1 when its last word is accepted.
//  If an rx LEN word and a command arrive in the same IDLE cycle, the drain wins: cmd_ready=0 that cycle.
//  TX: tx_valid held, tx_data stable until tx_ready; index increments per handshake; first tx word the cycle after cmd accept.
//  RX_WAIT/RX: rx_ready=1 always (never back-pressures the system).
//  Response checks: LEN==4 for read / 3 for write, DEST==HOST_ADDR, SRC==latched cmd_dest, TYPE==00, SUB matches.
//  SUB values: RESP_READ16_OK=4'b1000, RESP_READ16_ERR=4'b1001, RESP_WRITE16_OK=4'b1100, RESP_WRITE16_ERR=4'b1101.
//  *_ERR SUB or any failed check -> rsp_err=1, rsp_rdata=0; remaining words of that packet still drained.
//  LEN==0 response: counted as malformed (rsp_err), no further words consumed.
//  DONE: rsp_valid pulses one cycle after the last response word; IDLE (cmd_ready=1) on the following cycle.
//  Min read latency: 5 tx handshakes + response + 2 cycles.
// CONFIGURATION
//  OSD_HOST_TIMEOUT_EN defined: counter starts on the last tx handshake and clears on the rx LEN word.
//    Reaching TIMEOUT_CYC in RX_WAIT -> DONE with rsp_err=1, rsp_rdata=0; a late response is later drained.
//  Undefined: RX_WAIT waits forever, no counter logic; TIMEOUT_CYC unused.
// STRUCTURE
//  Package osd_host_pkg: state enum, FLAGS field widths, SUB constants, LEN_READ_REQ=4, LEN_WRITE_REQ=5,
//    LEN_READ_RSP=4, LEN_WRITE_RSP=3, TYPE_REG=2'b00.
//  Sub-module osd_host_pkt_rx: rx word counter, header capture, check flags, drain/done pulses; FSM in top.
// TESTING
//  1 Read dest=16'h0003 addr=16'h0000 -> tx 0004,0003,0000,0000,0000; reply 0004,0000,0003,2000,ABCD -> rsp_rdata=ABCD, rsp_err=0.
//  2 Write dest=0002 addr=0201 data=55AA, tx_ready toggling 1/0 -> tx 0005,0002,0000,1000,0201,55AA words held; reply 0003,0000,0002,3000 -> rsp_err=0.
//  3 Read reply FLAGS=2400 (READ16_ERR) -> rsp_err=1, rsp_rdata=0; reply with DEST=0001 -> rsp_err=1, all 5 words drained.
//  4 Unsolicited 3-word packet in IDLE -> drop_cnt=1, no rsp_valid; command same cycle as its LEN -> accepted only after drain.
//  5 OSD_HOST_TIMEOUT_EN, TIMEOUT_CYC=16, no reply -> rsp_valid with rsp_err=1 at cycle 16; late reply -> drop_cnt+1.
//  6 rst asserted in the middle of TX -> next cycle tx_valid=0, cmd_ready=0, drop_cnt=0; new command completes normally.

Source files
------------

// File: rtl/osd_host_pkg.sv
// Shared types, packet constants and word builders for the simulation-side OSD register host.
package osd_host_pkg;

  typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_WAIT, S_RX, S_DONE} state_t;

  localparam int FLAGS_TYPE_W = 2;
  localparam int FLAGS_SUB_W  = 4;
  localparam int FLAGS_PAD_W  = 16 - FLAGS_TYPE_W - FLAGS_SUB_W;

  localparam logic [FLAGS_TYPE_W-1:0] TYPE_REG = 2'b00;

  localparam logic [FLAGS_SUB_W-1:0] REQ_READ16       = 4'b0000;
  localparam logic [FLAGS_SUB_W-1:0] REQ_WRITE16      = 4'b0100;
  localparam logic [FLAGS_SUB_W-1:0] RESP_READ16_OK   = 4'b1000;
  localparam logic [FLAGS_SUB_W-1:0] RESP_READ16_ERR  = 4'b1001;
  localparam logic [FLAGS_SUB_W-1:0] RESP_WRITE16_OK  = 4'b1100;
  localparam logic [FLAGS_SUB_W-1:0] RESP_WRITE16_ERR = 4'b1101;

  localparam logic [15:0] LEN_READ_REQ  = 16'd4;
  localparam logic [15:0] LEN_WRITE_REQ = 16'd5;
  localparam logic [15:0] LEN_READ_RSP  = 16'd4;
  localparam logic [15:0] LEN_WRITE_RSP = 16'd3;

  function automatic logic [15:0] mk_flags(input logic [FLAGS_SUB_W-1:0] sub);
    return {TYPE_REG, sub, {FLAGS_PAD_W{1'b0}}};
  endfunction

  function automatic logic [FLAGS_SUB_W-1:0] rsp_sub(input logic write, input logic ok);
    logic [FLAGS_SUB_W-1:0] s;
    if (write) s = ok ? RESP_WRITE16_OK : RESP_WRITE16_ERR;
    else       s = ok ? RESP_READ16_OK  : RESP_READ16_ERR;
    return s;
  endfunction

  // Word idx of a request packet, idx 0 being the LEN word.
  function automatic logic [15:0] req_word(input logic write, input logic [15:0] dest,
                                           input logic [15:0] src, input logic [15:0] addr,
                                           input logic [15:0] wdata, input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = write ? LEN_WRITE_REQ : LEN_READ_REQ;
      3'd1:    w = dest;
      3'd2:    w = src;
      3'd3:    w = mk_flags(write ? REQ_WRITE16 : REQ_READ16);
      3'd4:    w = addr;
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic rsp_flags_ok(input logic [15:0] flags, input logic write);
    return flags[15 -: (FLAGS_TYPE_W + FLAGS_SUB_W)] == {TYPE_REG, rsp_sub(write, 1'b1)};
  endfunction

endpackage

// File: rtl/osd_host_pkt_rx.sv
// Receive-side packet walker: counts words, captures read data and accumulates response checks.
module osd_host_pkt_rx
  import osd_host_pkg::*;
#(
  parameter logic [15:0] HOST_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_fire,
  input  logic [15:0] rx_data,
  input  logic        exp_write,
  input  logic [15:0] exp_src,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [15:0] pkt_rdata,
  output logic        in_pkt
);

  logic [15:0] idx_q, idx_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        word_err;

  always_comb begin
    idx_d    = idx_q;
    len_d    = len_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    word_err = 1'b0;
    pkt_done = 1'b0;
    if (rx_fire) begin
      if (idx_q == 16'd0) begin
        len_d    = rx_data;
        rdata_d  = 16'd0;
        word_err = rx_data != (exp_write ? LEN_WRITE_RSP : LEN_READ_RSP);
        err_d    = word_err;
        // A zero LEN ends the packet on this word; nothing else is consumed.
        if (rx_data == 16'd0) pkt_done = 1'b1;
        else                  idx_d    = 16'd1;
      end else begin
        case (idx_q)
          16'd1:   word_err = rx_data != HOST_ADDR;
          16'd2:   word_err = rx_data != exp_src;
          16'd3:   word_err = !rsp_flags_ok(rx_data, exp_write);
          16'd4:   if (!exp_write) rdata_d = rx_data;
          default: word_err = 1'b0;
        endcase
        err_d = err_q | word_err;
        if (idx_q == len_q) begin
          pkt_done = 1'b1;
          idx_d    = 16'd0;
        end else begin
          idx_d = idx_q + 16'd1;
        end
      end
    end
    pkt_err   = err_d;
    pkt_rdata = rdata_d;
    in_pkt    = idx_d != 16'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 16'd0;
      len_q   <= 16'd0;
      rdata_q <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/osd_host_reg_master_sim.sv
// GLIP-side host that turns register commands into DII packets and parses responses.
// Optional response timeout is enabled with the OSD_HOST_TIMEOUT_EN macro.
module osd_host_reg_master_sim
  import osd_host_pkg::*;
#(
  parameter logic [15:0] HOST_ADDR   = 16'h0000,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_dest,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] drop_cnt
);

  state_t      state_q, state_d;
  logic        cmd_write_q, cmd_write_d;
  logic [15:0] cmd_dest_q, cmd_dest_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_wdata_q, cmd_wdata_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rx_ready_q, rx_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
`ifdef OSD_HOST_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  logic        rx_fire, cmd_fire;
  logic        pkt_done, pkt_err, in_pkt;
  logic [15:0] pkt_rdata;
  logic [15:0] req_len;

  // A LEN word arriving in IDLE starts a drain and takes priority over a command.
  assign cmd_ready = cmd_ready_q & ~(rx_valid & rx_ready_q);
  assign rx_fire   = rx_valid & rx_ready_q;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign req_len   = cmd_write_q ? LEN_WRITE_REQ : LEN_READ_REQ;

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign rx_ready  = rx_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign drop_cnt  = drop_cnt_q;

  osd_host_pkt_rx #(.HOST_ADDR(HOST_ADDR)) u_pkt_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_fire   (rx_fire),
    .rx_data   (rx_data),
    .exp_write (cmd_write_q),
    .exp_src   (cmd_dest_q),
    .pkt_done  (pkt_done),
    .pkt_err   (pkt_err),
    .pkt_rdata (pkt_rdata),
    .in_pkt    (in_pkt)
  );

  always_comb begin
    state_d     = state_q;
    cmd_write_d = cmd_write_q;
    cmd_dest_d  = cmd_dest_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    tx_idx_d    = tx_idx_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef OSD_HOST_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_fire && pkt_done && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        if (cmd_fire) begin
          cmd_write_d = cmd_write;
          cmd_dest_d  = cmd_dest;
          cmd_addr_d  = cmd_addr;
          cmd_wdata_d = cmd_wdata;
          tx_idx_d    = 3'd0;
          tx_valid_d  = 1'b1;
          tx_data_d   = req_word(cmd_write, cmd_dest, HOST_ADDR, cmd_addr, cmd_wdata, 3'd0);
          state_d     = S_TX;
        end
      end
      S_TX: begin
        if (tx_ready) begin
          if ({13'd0, tx_idx_q} == req_len) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 16'd0;
            state_d    = S_RX_WAIT;
`ifdef OSD_HOST_TIMEOUT_EN
            to_cnt_d   = 32'd0;
`endif
          end else begin
            tx_idx_d  = tx_idx_q + 3'd1;
            tx_data_d = req_word(cmd_write_q, cmd_dest_q, HOST_ADDR, cmd_addr_q, cmd_wdata_q,
                                 tx_idx_d);
          end
        end
      end
      S_RX_WAIT, S_RX: begin
        if (rx_fire && pkt_done) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pkt_err;
          rsp_rdata_d = (pkt_err || cmd_write_q) ? 16'd0 : pkt_rdata;
        end else if (rx_fire) begin
          state_d = S_RX;
`ifdef OSD_HOST_TIMEOUT_EN
          to_cnt_d = 32'd0;
        end else if (state_q == S_RX_WAIT) begin
          if (to_cnt_q + 32'd1 >= 32'(TIMEOUT_CYC)) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 16'd0;
          end else begin
            to_cnt_d = to_cnt_q + 32'd1;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE) && !in_pkt;
    rx_ready_d  = (state_d == S_IDLE) || (state_d == S_RX_WAIT) || (state_d == S_RX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_write_q <= 1'b0;
      cmd_dest_q  <= 16'd0;
      cmd_addr_q  <= 16'd0;
      cmd_wdata_q <= 16'd0;
      tx_idx_q    <= 3'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 16'd0;
      cmd_ready_q <= 1'b0;
      rx_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'd0;
      rsp_err_q   <= 1'b0;
      drop_cnt_q  <= 16'd0;
`ifdef OSD_HOST_TIMEOUT_EN
      to_cnt_q    <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      cmd_dest_q  <= cmd_dest_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      tx_idx_q    <= tx_idx_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      cmd_ready_q <= cmd_ready_d;
      rx_ready_q  <= rx_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef OSD_HOST_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

endmodule
